// File: rtl/hamming_uart_pkg.sv
// Shared types and constants for the Hamming(7,4) UART transmit path.
// Build option: HAMMING_UART_PARITY_EN adds an even-parity bit to each frame.
package hamming_uart_pkg;

    localparam int CODE_W           = 7;
    localparam int BIT_CNT_W        = $clog2(CODE_W);
    localparam int FRAME_BITS_NOPAR = 9;
    localparam int FRAME_BITS_PAR   = 10;

`ifdef HAMMING_UART_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_PAR;
`else
    localparam int FRAME_BITS = FRAME_BITS_NOPAR;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef HAMMING_UART_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/hamming_uart_baud_gen.sv
// Bit-period counter: counts enabled cycles 0..CLKS_PER_BIT-1 and flags the last one.
// Held at zero while restart is high so a new frame always starts on a full period.
module hamming_uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic restart,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (ena) begin
            if (restart || cnt == LAST)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    // Not gated by ena, so a frozen block keeps presenting the same value.
    assign bit_end = (cnt == LAST);

endmodule

// File: rtl/hamming_uart_tx.sv
// UART serializer for Hamming code words: start, 7 code bits LSB first, [parity], stop.
// A one-word holding buffer covers words arriving mid-frame. Option: HAMMING_UART_PARITY_EN.
module hamming_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CODE_W       = hamming_uart_pkg::CODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    import hamming_uart_pkg::*;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(CODE_W - 1);

    tx_state_t             state, state_n;
    logic [CODE_W-1:0]     shift, shift_n;
    logic [CODE_W-1:0]     hold, hold_n;
    logic                  hold_vld, hold_vld_n;
    logic                  par, par_n;
    logic [BIT_CNT_W-1:0]  bit_cnt, bit_n;
    logic                  tx_q, tx_n;
    logic                  ovf, ovf_n;
    logic                  taken;
    logic                  bit_end;

    hamming_uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .restart(state == IDLE),
        .bit_end(bit_end)
    );

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        hold_n     = hold;
        hold_vld_n = hold_vld;
        par_n      = par;
        bit_n      = bit_cnt;
        ovf_n      = ovf;
        taken      = 1'b0;

        if (ena) begin
            unique case (state)
                IDLE: begin
                    if (hold_vld) begin
                        shift_n    = hold;
                        par_n      = ^hold;
                        hold_vld_n = 1'b0;
                        state_n    = START;
                    end else if (code_valid) begin
                        shift_n = code_in;
                        par_n   = ^code_in;
                        taken   = 1'b1;
                        state_n = START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_n   = '0;
                        state_n = DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_n = shift >> 1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef HAMMING_UART_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef HAMMING_UART_PARITY_EN
                PARITY: begin
                    if (bit_end)
                        state_n = STOP;
                end
`endif
                STOP: begin
                    // Pop in the last stop cycle so the next start bit follows with no gap.
                    if (bit_end) begin
                        if (hold_vld) begin
                            shift_n    = hold;
                            par_n      = ^hold;
                            hold_vld_n = 1'b0;
                            state_n    = START;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase

            // Checked against the post-pop occupancy, so a pop and a new word can coincide.
            if (code_valid && !taken) begin
                if (!hold_vld_n) begin
                    hold_n     = code_in;
                    hold_vld_n = 1'b1;
                end else begin
                    ovf_n = 1'b1;
                end
            end
        end

        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef HAMMING_UART_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            hold     <= '0;
            hold_vld <= 1'b0;
            par      <= 1'b0;
            bit_cnt  <= '0;
            tx_q     <= 1'b1;
            ovf      <= 1'b0;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            hold     <= hold_n;
            hold_vld <= hold_vld_n;
            par      <= par_n;
            bit_cnt  <= bit_n;
            tx_q     <= tx_n;
            ovf      <= ovf_n;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state != IDLE);
    assign frame_done = (state == STOP) && bit_end;
    assign ready      = !hold_vld;
    assign overflow   = ovf;

endmodule

// File: tb/tb_hamming_uart_tx.sv
// Scoreboard bench for hamming_uart_tx: stimulus queues expected frames, a monitor
// reassembles each frame from tx and checks it when frame_done pulses.
module tb_hamming_uart_tx;

    localparam int CPB = 4;
`ifdef HAMMING_UART_PARITY_EN
    localparam int FB = 10;
`else
    localparam int FB = 9;
`endif
    localparam int FL = FB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       code_valid = 1'b0;
    logic [6:0] code_in = '0;
    logic       ready, tx, busy, frame_done, overflow;

    hamming_uart_tx #(.CLKS_PER_BIT(CPB), .CODE_W(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .code_in   (code_in),
        .code_valid(code_valid),
        .ready     (ready),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [6:0] word;
        int         start;
        int         done;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   T       = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - T);
        end
    endtask

    // Returns just after the edge that starts cycle c.
    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns at the falling edge inside cycle c.
    task automatic sample(input int c);
        at(c);
        @(negedge clk);
    endtask

    task automatic pulse(input int c, input logic [6:0] w);
        at(c);
        code_in    = w;
        code_valid = 1'b1;
        at(c + 1);
        code_valid = 1'b0;
    endtask

    task automatic push(input logic [6:0] w, input int s, input int d);
        exp_t e;
        e.word  = w;
        e.start = s;
        e.done  = d;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        at(cyc + 2);
        rst = 1'b0;
        T = cyc;
    endtask

    function automatic logic exp_bit(input logic [6:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k <= 7) return w[k-1];
        if (FB == 10 && k == 8) return ^w;
        return 1'b1;
    endfunction

    // Monitor: samples tx only on enabled cycles, so every bit spans exactly CPB samples.
    logic in_frame = 1'b0;
    int   fstart   = 0;
    int   nsamp    = 0;
    logic samp [0:127];

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (busy && !in_frame) begin
                in_frame = 1'b1;
                fstart   = cyc;
                nsamp    = 0;
            end
            if (in_frame && ena) begin
                if (nsamp < 128) samp[nsamp] = tx;
                nsamp++;
            end
            if (in_frame && ena && frame_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    exp_t e;
                    int   errs;
                    e    = sb.pop_front();
                    errs = 0;
                    for (int k = 0; k < FB; k++)
                        for (int s = 0; s < CPB; s++)
                            if (samp[k*CPB+s] !== exp_bit(e.word, k)) errs++;
                    chk("frame_start", fstart - T, e.start - T);
                    chk("frame_done_cycle", cyc - T, e.done - T);
                    chk("frame_len", nsamp, FL);
                    chk("frame_bits_bad", errs, 0);
                end
                in_frame = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int bad_tx, bad_busy, bad_ready, bad_ovf;

        // Reset state and quiet idle line
        do_reset();
        sample(T);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_done", frame_done, 0);
        bad_tx = 0; bad_busy = 0; bad_ready = 0; bad_ovf = 0;
        for (int i = 1; i <= 50; i++) begin
            sample(T + i);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
            if (ready !== 1'b1) bad_ready++;
            if (overflow !== 1'b0) bad_ovf++;
        end
        chk("idle_tx_bad", bad_tx, 0);
        chk("idle_busy_bad", bad_busy, 0);
        chk("idle_ready_bad", bad_ready, 0);
        chk("idle_overflow_bad", bad_ovf, 0);

        // Single word, one-cycle latency to start bit
        do_reset();
        push(7'b1010101, T + 11, T + 10 + FL);
        pulse(T + 10, 7'b1010101);
        sample(T + 11);
        chk("single_start_low", tx, 0);
        sample(T + 10 + FL);
        chk("single_frame_done", frame_done, 1);
        sample(T + 11 + FL);
        chk("single_busy_after", busy, 0);
        chk("single_frame_done_clear", frame_done, 0);

        // Back-to-back frames through the holding buffer
        do_reset();
        push(7'h2A, T + 11, T + 10 + FL);
        push(7'h55, T + 11 + FL, T + 10 + 2*FL);
        pulse(T + 10, 7'h2A);
        sample(T + 15);
        chk("b2b_ready_before", ready, 1);
        pulse(T + 20, 7'h55);
        sample(T + 21);
        chk("b2b_ready_buffered", ready, 0);
        sample(T + 11 + FL);
        chk("b2b_second_start", tx, 0);
        chk("b2b_ready_popped", ready, 1);
        sample(T + 20 + 2*FL);
        chk("b2b_overflow", overflow, 0);

        // Overflow: third word dropped, flag sticky
        do_reset();
        push(7'h11, T + 11, T + 10 + FL);
        push(7'h13, T + 11 + FL, T + 10 + 2*FL);
        pulse(T + 10, 7'h11);
        pulse(T + 12, 7'h13);
        sample(T + 14);
        chk("ovf_before", overflow, 0);
        pulse(T + 14, 7'h7F);
        sample(T + 15);
        chk("ovf_set", overflow, 1);
        sample(T + 30 + 2*FL);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_two_frames_only", sb.size(), 0);

        // ena low for 10 cycles mid-DATA; code_valid ignored meanwhile
        do_reset();
        chk("ovf_cleared_by_reset", overflow, 0);
        push(7'h33, T + 11, T + 20 + FL);
        pulse(T + 10, 7'h33);
        at(T + 20);
        ena = 1'b0;
        at(T + 25);
        code_in    = 7'h7F;
        code_valid = 1'b1;
        at(T + 26);
        code_valid = 1'b0;
        sample(T + 27);
        chk("ena_low_ready", ready, 1);
        at(T + 30);
        ena = 1'b1;
        sample(T + 19 + FL);
        chk("ena_stretch_busy", busy, 1);
        sample(T + 21 + FL);
        chk("ena_stretch_busy_end", busy, 0);
        sample(T + 40 + FL);
        chk("ena_no_extra_frame", busy, 0);

        // Reset mid-DATA with a word buffered, then a clean frame
        do_reset();
        pulse(T + 10, 7'h0F);
        pulse(T + 15, 7'h3C);
        sample(T + 17);
        chk("mid_rst_ready_before", ready, 0);
        at(T + 20);
        rst = 1'b1;
        at(T + 21);
        rst = 1'b0;
        sample(T + 21);
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", ready, 1);
        push(7'h5A, T + 31, T + 30 + FL);
        pulse(T + 30, 7'h5A);
        sample(T + 40 + FL);
        chk("mid_rst_idle_after", busy, 0);

`ifdef HAMMING_UART_PARITY_EN
        // Parity bit of 0000111 is 1, sent just before the stop bit
        do_reset();
        push(7'b0000111, T + 11, T + 50);
        pulse(T + 10, 7'b0000111);
        sample(T + 43);
        chk("parity_bit", tx, 1);
        sample(T + 51);
        chk("parity_busy_after", busy, 0);
`endif

        at(cyc + 20);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_uart_tx.md
Name: hamming_uart_tx

Overview:
- Downstream stage of the Hamming(7,4) encoder: takes each 7-bit code word with its valid pulse and serializes it onto a UART line.
- Frame: start bit (0), 7 code bits LSB first (code_in[0] first), optional parity bit, stop bit (1).
- A one-entry holding buffer absorbs a word arriving mid-frame, because the encoder gives no backpressure.
- Output feeds the chip pin / loopback path to the receiver.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535.
- CODE_W, 7, code word width; fixed to 7 for this design, exposed for the package.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- ena  input  1  block enable; when 0 all state, counters and outputs hold
- code_in  input  7  Hamming code word from encoder
- code_valid  input  1  code_in valid this cycle (encoder valid_out)
- ready  output  1  1 when the holding buffer is empty (advisory only)
- tx  output  1  serial line, idle high
- busy  output  1  1 while a frame is on the line
- frame_done  output  1  one-cycle pulse in the last cycle of the stop bit
- overflow  output  1  sticky: a word was dropped

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - tx=1, busy=0, frame_done=0, overflow=0, ready=1
  - buffer empty, FSM=IDLE, bit and baud counters=0
- Reset mid-frame aborts the frame; tx returns to 1 on the next edge.
- ena=0 freezes everything, including the baud counter. code_valid is ignored while ena=0.
- Word acceptance (ena=1, code_valid=1):
  - FSM=IDLE and buffer empty: load the shift register directly.
  - Otherwise, buffer empty: store the word in the buffer.
  - Otherwise: drop the word and set overflow=1.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE -> START on the cycle after acceptance (or after a buffer pop); tx=0 from that edge.
  - Each state lasts exactly CLKS_PER_BIT enabled cycles. The baud counter runs 0..CLKS_PER_BIT-1 and wraps.
  - START -> DATA.
  - DATA sends bits 0..6 via a bit counter 0..6. After bit 6 it goes to PARITY if enabled, else STOP.
  - STOP -> IDLE, or straight back to START if the buffer is non-empty.
- Back-to-back frames: the buffer pops in the last STOP cycle (frame_done=1), and the next start bit begins on the following cycle with no idle gap.
- Simultaneous pop and code_valid in the same cycle: the incoming word goes into the freed buffer slot, with no overflow.
- Latency: code_valid at cycle N (idle) -> tx falls at N+1.
- Frame length: 9*CLKS_PER_BIT cycles (10*CLKS_PER_BIT with parity).
- busy=1 from START entry through the last STOP cycle inclusive.
- ready = buffer empty, registered.
- tx is driven from a register (no combinational glitch).

Optional Feature:
- Macro HAMMING_UART_PARITY_EN.
- Defined: insert an even-parity bit (XOR of the 7 code bits) between the last data bit and the stop bit. Frame = 10 bits.
- Undefined: the PARITY state and its logic are absent. Frame = 9 bits.

Decomposition:
- Package hamming_uart_pkg:
  - CODE_W=7
  - FSM state enum (tx_state_t)
  - FRAME_BITS constants for the parity and no-parity cases
- Natural sub-module: hamming_uart_baud_gen.
  - Counter with CLKS_PER_BIT parameter, plus ena and a restart input.
  - Emits a bit_end pulse. It is shared later with the receiver.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4: tx=1, busy=0, ready=1, overflow=0 for 50 cycles.
- Single word:
  - Stimulus: code_in=7'b1010101 pulse at cycle 10.
  - Response: tx low cycles 11-14, then bits 1,0,1,0,1,0,1 for 4 cycles each, then high for the stop bit.
  - frame_done pulses at cycle 46; busy is low at cycle 47.
- Back-to-back:
  - Stimulus: 7'h2A at cycle 10, 7'h55 at cycle 20.
  - Response: ready=0 from cycle 21; the second start bit begins at cycle 47; no overflow.
- Overflow:
  - Stimulus: three words at cycles 10, 12, 14.
  - Response: the third is dropped, overflow=1 from cycle 15 and stays set; only two frames are sent.
- ena low for 10 cycles mid-DATA: every bit period containing the gap is stretched by exactly 10 cycles; bit values are unchanged.
- Reset asserted mid-DATA: tx=1, busy=0, buffer emptied on the next edge. A later word transmits correctly.
- With HAMMING_UART_PARITY_EN, code 7'b0000111: parity bit 1 is sent before the stop bit; the frame is 40 cycles.
